rotary_quadrature_decoder: RTL and testbench

Upstream front end for the menu controller's rotary inputs. It takes the raw, asynchronous, bouncy rotary_a/rotary_b pins, synchronizes and filters each one, and decodes full detent-to-detent quadrature cycles. Each completed detent produces a single-cycle rotary_event with a rotary_left direction flag. It also keeps a wrapping detent position count and flags illegal sequences. It replaces the existing rotary front end with a filtered, glitch-tolerant version.

---
 rtl/rotary_quadrature_decoder.sv | 158 +++++++++++++++
 tb/tb_rotary_quadrature_decoder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotary_quadrature_decoder.sv
// Rotary encoder front end: 2-flop synchronizers, per-channel persistence filters
// and a detent-to-detent quadrature FSM producing events, direction and a position count.
module rotary_quadrature_decoder #(
   parameter int FILTER_CYCLES = 50000,
   parameter int CNT_W         = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rotary_a,
   input  logic       rotary_b,
   output logic       rotary_event,
   output logic       rotary_left,
   output logic [7:0] position,
   output logic       seq_error,
   output logic       a_filt,
   output logic       b_filt,
   output logic [2:0] o_fsm_state
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_R1     = 3'd1;
   localparam logic [2:0] S_R2     = 3'd2;
   localparam logic [2:0] S_R3     = 3'd3;
   localparam logic [2:0] S_L1     = 3'd4;
   localparam logic [2:0] S_L2     = 3'd5;
   localparam logic [2:0] S_L3     = 3'd6;
   localparam logic [2:0] S_RESYNC = 3'd7;

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(FILTER_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

   // Channel vectors are packed as {A, B}.
   logic [1:0]       r_sync1;
   logic [1:0]       r_sync2;
   logic [1:0]       r_filt;
   logic [CNT_W-1:0] r_cnt [2];

   logic [2:0] r_state;
   logic       r_event;
   logic       r_left;
   logic [7:0] r_pos;
   logic       r_err;

   logic [2:0] w_next;
   logic       w_event;
   logic       w_left;
   logic       w_err;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 2'b11;
         r_sync2 <= 2'b11;
      end else begin
         r_sync1 <= {rotary_a, rotary_b};
         r_sync2 <= r_sync1;
      end
   end

   // A channel's filtered value moves only after FILTER_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_filt <= 2'b11;
         for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] == r_filt[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == C_LAST) begin
               r_filt[i] <= r_sync2[i];
               r_cnt[i]  <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + C_ONE;
            end
         end
      end
   end

   always_comb begin
      w_next  = r_state;
      w_event = 1'b0;
      w_left  = 1'b0;
      w_err   = 1'b0;
      case (r_state)
         S_IDLE: case (r_filt)
            2'b01:   w_next = S_R1;
            2'b10:   w_next = S_L1;
            2'b00:   begin w_next = S_RESYNC; w_err = 1'b1; end
            default: ;
         endcase
         S_R1: case (r_filt)
            2'b00:   w_next = S_R2;
            2'b11:   w_next = S_IDLE;
            2'b10:   begin w_next = S_RESYNC; w_err = 1'b1; end
            default: ;
         endcase
         S_R2: case (r_filt)
            2'b10:   w_next = S_R3;
            2'b01:   w_next = S_R1;
            2'b11:   begin w_next = S_RESYNC; w_err = 1'b1; end
            default: ;
         endcase
         S_R3: case (r_filt)
            2'b11:   begin w_next = S_IDLE; w_event = 1'b1; w_left = 1'b0; end
            2'b00:   w_next = S_R2;
            2'b01:   begin w_next = S_RESYNC; w_err = 1'b1; end
            default: ;
         endcase
         S_L1: case (r_filt)
            2'b00:   w_next = S_L2;
            2'b11:   w_next = S_IDLE;
            2'b01:   begin w_next = S_RESYNC; w_err = 1'b1; end
            default: ;
         endcase
         S_L2: case (r_filt)
            2'b01:   w_next = S_L3;
            2'b10:   w_next = S_L1;
            2'b11:   begin w_next = S_RESYNC; w_err = 1'b1; end
            default: ;
         endcase
         S_L3: case (r_filt)
            2'b11:   begin w_next = S_IDLE; w_event = 1'b1; w_left = 1'b1; end
            2'b00:   w_next = S_L2;
            2'b10:   begin w_next = S_RESYNC; w_err = 1'b1; end
            default: ;
         endcase
         // Errors are reported once on entry; here we only wait for the detent.
         S_RESYNC: if (r_filt == 2'b11) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_event <= 1'b0;
         r_left  <= 1'b0;
         r_pos   <= 8'd0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_event <= w_event;
         r_err   <= w_err;
         if (w_event) begin
            r_left <= w_left;
            r_pos  <= w_left ? (r_pos - 8'd1) : (r_pos + 8'd1);
         end
      end
   end

   assign rotary_event = r_event;
   assign rotary_left  = r_left;
   assign position     = r_pos;
   assign seq_error    = r_err;
   assign a_filt       = r_filt[1];
   assign b_filt       = r_filt[0];
   assign o_fsm_state  = r_state;

endmodule

// File: tb/tb_rotary_quadrature_decoder.sv
// Bench for rotary_quadrature_decoder: directed scenarios then a random walk,
// every cycle compared against a gray-code position model of the encoder.
module tb_rotary_quadrature_decoder;

   localparam int F = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       rotary_a;
   logic       rotary_b;
   logic       rotary_event;
   logic       rotary_left;
   logic [7:0] position;
   logic       seq_error;
   logic       a_filt;
   logic       b_filt;
   logic [2:0] o_fsm_state;

   rotary_quadrature_decoder #(.FILTER_CYCLES(F), .CNT_W(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .rotary_a     (rotary_a),
      .rotary_b     (rotary_b),
      .rotary_event (rotary_event),
      .rotary_left  (rotary_left),
      .position     (position),
      .seq_error    (seq_error),
      .a_filt       (a_filt),
      .b_filt       (b_filt),
      .o_fsm_state  (o_fsm_state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int ev_cnt = 0;
   int err_cnt = 0;

   // Reference model: raw samples delayed two edges, per-channel run length,
   // and the rotor tracked as a direction plus quarter-steps taken from the detent.
   logic [1:0] m_dly[$];
   logic [1:0] m_filt;
   logic [1:0] m_last_s;
   int         m_run [2];
   int         m_mode;
   int         m_dir;
   int         m_prog;
   logic       m_event;
   logic       m_err;
   logic       m_left;
   logic [7:0] m_pos;

   function automatic int ridx(input logic [1:0] c);
      case (c)
         2'b11:   return 0;
         2'b01:   return 1;
         2'b00:   return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [1:0] code_of(input int i);
      case (i)
         0:       return 2'b11;
         1:       return 2'b01;
         2:       return 2'b00;
         default: return 2'b10;
      endcase
   endfunction

   task automatic model_reset();
      m_dly    = {2'b11, 2'b11};
      m_filt   = 2'b11;
      m_last_s = 2'b11;
      m_run[0] = 0;
      m_run[1] = 0;
      m_mode   = 0;
      m_dir    = 0;
      m_prog   = 0;
      m_event  = 1'b0;
      m_err    = 1'b0;
      m_left   = 1'b0;
      m_pos    = 8'd0;
   endtask

   task automatic model_step();
      int n, cur, d, stp;
      logic [1:0] s;
      m_event = 1'b0;
      m_err   = 1'b0;
      n = ridx(m_filt);
      if (m_mode == 2) begin
         if (n == 0) m_mode = 0;
      end else begin
         cur = (m_mode == 0) ? 0 : ((m_dir > 0) ? m_prog : 4 - m_prog);
         d = (n - cur + 4) % 4;
         if (d == 2) begin
            m_mode = 2;
            m_err  = 1'b1;
         end else if (d != 0) begin
            stp = (d == 1) ? 1 : -1;
            if (m_mode == 0) begin
               m_mode = 1;
               m_dir  = stp;
               m_prog = 1;
            end else if (stp == m_dir) begin
               m_prog++;
               if (m_prog == 4) begin
                  m_mode  = 0;
                  m_event = 1'b1;
                  m_left  = (m_dir < 0);
                  m_pos   = m_pos + 8'(m_dir);
               end
            end else begin
               m_prog--;
               if (m_prog == 0) m_mode = 0;
            end
         end
      end
      s = m_dly.pop_front();
      m_dly.push_back({rotary_a, rotary_b});
      for (int ch = 0; ch < 2; ch++) begin
         if (s[ch] == m_last_s[ch]) m_run[ch]++;
         else m_run[ch] = 1;
         if (s[ch] != m_filt[ch] && m_run[ch] >= F) m_filt[ch] = s[ch];
      end
      m_last_s = s;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) model_step();
      else model_reset();
      @(negedge clk);
      chk("event", 32'(rotary_event), 32'(m_event));
      chk("seq_error", 32'(seq_error), 32'(m_err));
      chk("left", 32'(rotary_left), 32'(m_left));
      chk("position", 32'(position), 32'(m_pos));
      chk("a_filt", 32'(a_filt), 32'(m_filt[1]));
      chk("b_filt", 32'(b_filt), 32'(m_filt[0]));
      if (rotary_event) ev_cnt++;
      if (seq_error) err_cnt++;
   endtask

   task automatic drive(input logic [1:0] ab, input int n);
      rotary_a = ab[1];
      rotary_b = ab[0];
      repeat (n) tick();
   endtask

   initial begin
      int ev0, er0, lat, cur, nxt, r, hold;
      model_reset();
      reset    = 1'b0;
      rotary_a = 1'b1;
      rotary_b = 1'b1;
      repeat (3) tick();
      reset = 1'b1;

      // Idle after reset release.
      ev0 = ev_cnt; er0 = err_cnt;
      drive(2'b11, 20);
      chk("s1_events", 32'(ev_cnt - ev0), 0);
      chk("s1_errors", 32'(err_cnt - er0), 0);
      chk("s1_position", 32'(position), 0);
      chk("s1_state_idle", 32'(o_fsm_state), 0);

      // One right detent, event 7 cycles after the final raw edge.
      ev0 = ev_cnt;
      drive(2'b01, 10); drive(2'b00, 10); drive(2'b10, 10);
      rotary_a = 1'b1; rotary_b = 1'b1;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (rotary_event && lat < 0) lat = i;
      end
      chk("s2_latency", 32'(lat), 7);
      chk("s2_events", 32'(ev_cnt - ev0), 1);
      chk("s2_left", 32'(rotary_left), 0);
      chk("s2_position", 32'(position), 1);

      // Two left detents, wrapping through zero.
      ev0 = ev_cnt;
      drive(2'b10, 10); drive(2'b00, 10); drive(2'b01, 10); drive(2'b11, 10);
      chk("s3_position_a", 32'(position), 0);
      drive(2'b10, 10); drive(2'b00, 10); drive(2'b01, 10); drive(2'b11, 10);
      chk("s3_events", 32'(ev_cnt - ev0), 2);
      chk("s3_left", 32'(rotary_left), 1);
      chk("s3_position_b", 32'(position), 255);

      // Bounce on A, then settle low.
      ev0 = ev_cnt; er0 = err_cnt;
      drive(2'b01, 2); drive(2'b11, 2); drive(2'b01, 2); drive(2'b11, 2);
      chk("s4_no_early_fall", 32'(a_filt), 1);
      rotary_a = 1'b0; rotary_b = 1'b1;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (!a_filt && lat < 0) lat = i;
      end
      chk("s4_filter_latency", 32'(lat), 2 + F);
      drive(2'b11, 10);
      chk("s4_errors", 32'(err_cnt - er0), 0);
      chk("s4_events", 32'(ev_cnt - ev0), 0);

      // Abandoned turn, then reversal mid-turn.
      ev0 = ev_cnt;
      drive(2'b01, 10); drive(2'b11, 10);
      chk("s5_abandon_events", 32'(ev_cnt - ev0), 0);
      chk("s5_abandon_pos", 32'(position), 255);
      drive(2'b01, 10); drive(2'b00, 10); drive(2'b01, 10);
      drive(2'b00, 10); drive(2'b10, 10); drive(2'b11, 10);
      chk("s5_reverse_events", 32'(ev_cnt - ev0), 1);
      chk("s5_reverse_left", 32'(rotary_left), 0);
      chk("s5_reverse_pos", 32'(position), 0);

      // Illegal double change, resync, then a left turn.
      ev0 = ev_cnt; er0 = err_cnt;
      drive(2'b00, 10);
      chk("s6_error_pulses", 32'(err_cnt - er0), 1);
      chk("s6_state_resync", 32'(o_fsm_state), 7);
      drive(2'b10, 10); drive(2'b11, 10);
      chk("s6_resync_events", 32'(ev_cnt - ev0), 0);
      chk("s6_state_back_idle", 32'(o_fsm_state), 0);
      drive(2'b10, 10); drive(2'b00, 10); drive(2'b01, 10); drive(2'b11, 10);
      chk("s6_left_events", 32'(ev_cnt - ev0), 1);
      chk("s6_left_dir", 32'(rotary_left), 1);
      chk("s6_left_pos", 32'(position), 255);
      chk("s6_error_total", 32'(err_cnt - er0), 1);

      // Reset asserted while in R2 takes effect without a clock edge.
      drive(2'b01, 10); drive(2'b00, 10);
      chk("s6_state_r2", 32'(o_fsm_state), 2);
      #2 reset = 1'b0;
      #1;
      chk("rst_event", 32'(rotary_event), 0);
      chk("rst_left", 32'(rotary_left), 0);
      chk("rst_position", 32'(position), 0);
      chk("rst_error", 32'(seq_error), 0);
      chk("rst_a_filt", 32'(a_filt), 1);
      chk("rst_b_filt", 32'(b_filt), 1);
      chk("rst_state", 32'(o_fsm_state), 0);
      drive(2'b11, 4);
      reset = 1'b1;
      drive(2'b11, 20);

      // Random walk with short holds (bounces), illegal jumps and occasional resets.
      cur = 0;
      for (int k = 0; k < 300; k++) begin
         r = $urandom_range(0, 9);
         if (r < 4) nxt = (cur + 1) % 4;
         else if (r < 8) nxt = (cur + 3) % 4;
         else nxt = $urandom_range(0, 3);
         hold = $urandom_range(1, 12);
         drive(code_of(nxt), hold);
         cur = nxt;
         if ($urandom_range(0, 40) == 0) begin
            reset = 1'b0;
            drive(code_of(cur), 2);
            reset = 1'b1;
         end
      end
      drive(2'b11, 20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
